// File: rtl/ping_pong_sequencer_pkg.sv
// Shared lab3 definitions: sequencer state encodings and ping-pong counter endpoints.
// latency: n/a; backpressure: n/a.
package ping_pong_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DWELL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'hF;
  localparam logic [3:0] CNT_MIN = 4'h0;

  // A fresh counter sits at 0 heading up; only a down-going 0 is a turnaround.
  function automatic logic is_bounce(input logic [3:0] cnt, input logic dir_up);
    return (cnt == CNT_MAX) || ((cnt == CNT_MIN) && !dir_up);
  endfunction

endpackage

// File: rtl/ping_pong_sequencer_tick_divider.sv
// Free-running divide-by-DIV prescaler; tick is a Moore decode of the wrap cycle.
// latency: first tick DIV-1 cycles after clr; backpressure: none (clr restarts the period).
module tick_divider
  import ping_pong_sequencer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ping_pong_sequencer.sv
// Sequences a ping-pong counter: clear, paced strobes, dwell after each bounce, stop after MAX_BOUNCES.
// latency: start -> CLEAR next cycle, first strobe DIV cycles later; backpressure: none, stop/start pulses only.
module ping_pong_sequencer
  import ping_pong_sequencer_pkg::*;
#(
  parameter int DIV         = 4,
  parameter int DWELL_TICKS = 2,
  parameter int MAX_BOUNCES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] cnt_in,
  input  logic       dir_in,
  output logic       cnt_en,
  output logic       cnt_rst_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] bounces
);

  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'((DWELL_TICKS > 0) ? DWELL_TICKS - 1 : 0);
  localparam logic [7:0] MAX_B = 8'(MAX_BOUNCES);

  state_t        state, state_nxt;
  logic [DW-1:0] dwell_cnt, dwell_nxt;
  logic [7:0]    bounces_q, bounces_nxt, bounces_inc;
  logic          tick, div_clr, bounce;

  // Prescaler only runs in RUN/DWELL so every RUN entry begins a fresh period.
  assign div_clr = (state == IDLE) || (state == CLEAR) || (state == DONE);

  tick_divider #(.DIV(DIV)) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .tick  (tick)
  );

  assign cnt_en      = (state == RUN) && tick;
  assign cnt_rst_n   = (state != CLEAR);
  assign busy        = (state == CLEAR) || (state == RUN) || (state == DWELL);
  assign done        = (state == DONE);
  assign bounces     = bounces_q;
  assign bounce      = cnt_en && is_bounce(cnt_in, dir_in);
  assign bounces_inc = bounces_q + 8'd1;

  always_comb begin
    state_nxt   = state;
    dwell_nxt   = dwell_cnt;
    bounces_nxt = bounces_q;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = stop ? IDLE : RUN;
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = CLEAR;
        end else if (bounce) begin
          bounces_nxt = bounces_inc;
          if (bounces_inc == MAX_B) begin
            state_nxt = DONE;
          end else if (DWELL_TICKS != 0) begin
            state_nxt = DWELL;
          end
        end
      end
      DWELL: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = CLEAR;
        end else if (tick) begin
          if (dwell_cnt == DWELL_LAST) begin
            state_nxt = RUN;
          end else begin
            dwell_nxt = dwell_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        if (start) state_nxt = CLEAR;
      end
      default: state_nxt = IDLE;
    endcase
    // Cleared on entry so the count already reads 0 during the CLEAR cycle.
    if (state_nxt == CLEAR) bounces_nxt = '0;
    if (state_nxt != DWELL) dwell_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      bounces_q <= '0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      bounces_q <= bounces_nxt;
    end
  end

endmodule

// File: tb/tb_ping_pong_sequencer.sv
// Bench: two sequencer instances (DIV=4/DWELL=2 and DIV=1/DWELL=0), each driving a behavioural ping-pong counter.
module tb_ping_pong_sequencer;

  logic clk, rst_n, start, stop;
  logic [1:0] en, crn, bsy, dn, dir;
  logic [3:0] cnt [2];
  logic [7:0] bnc [2];

  ping_pong_sequencer #(.DIV(4), .DWELL_TICKS(2), .MAX_BOUNCES(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cnt_in(cnt[0]), .dir_in(dir[0]), .cnt_en(en[0]), .cnt_rst_n(crn[0]),
    .busy(bsy[0]), .done(dn[0]), .bounces(bnc[0]));

  ping_pong_sequencer #(.DIV(1), .DWELL_TICKS(0), .MAX_BOUNCES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cnt_in(cnt[1]), .dir_in(dir[1]), .cnt_en(en[1]), .cnt_rst_n(crn[1]),
    .busy(bsy[1]), .done(dn[1]), .bounces(bnc[1]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Ping-pong counter 0..15..0, turns around on the strobe at an endpoint.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || !crn[i]) begin
        cnt[i] <= 4'd0; dir[i] <= 1'b1;
      end else if (en[i]) begin
        if (dir[i]) begin
          if (cnt[i] == 4'd15) begin cnt[i] <= 4'd14; dir[i] <= 1'b0; end
          else cnt[i] <= cnt[i] + 4'd1;
        end else begin
          if (cnt[i] == 4'd0) begin cnt[i] <= 4'd1; dir[i] <= 1'b1; end
          else cnt[i] <= cnt[i] - 4'd1;
        end
      end
    end
  end

  int n_chk, n_fail, cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Counter value after n strobes since a clear: triangle wave of period 30.
  function automatic int tri_val(input int n);
    int p;
    p = n % 30;
    return (p <= 15) ? p : 30 - p;
  endfunction

  // ---------------- reference model: strobe schedule per run ----------------
  typedef struct { bit en, crn, busy, done; int bnc, cnt; } exp_t;
  int sof [2][64];
  bit isb [2][64];
  int ns [2], mx [2], t0 [2], ps [2], held [2];

  // Strobe offsets from the CLEAR cycle: every D cycles, plus D*W extra after a bounce.
  function automatic void build(input int i, input int d, input int w, input int m);
    int off, nb;
    off = d; nb = 0; ns[i] = 0; mx[i] = m;
    for (int k = 1; nb < m; k++) begin
      sof[i][ns[i]] = off;
      isb[i][ns[i]] = (k == 16) || (k > 16 && (k - 16) % 15 == 0);
      if (isb[i][ns[i]]) nb++;
      off += isb[i][ns[i]] ? d * (w + 1) : d;
      ns[i]++;
    end
  endfunction

  function automatic exp_t model(input int i, input int c);
    exp_t e;
    int lim_b, lim_s, nb, n, t;
    bit stopped;
    e = '{en: 0, crn: 1, busy: 0, done: 0, bnc: 0, cnt: 0};
    if (t0[i] < 0) return e;
    if (c == t0[i]) begin
      e.crn = 0; e.busy = 1; e.cnt = held[i];
      return e;
    end
    stopped = (ps[i] >= 0) && (c > ps[i]);
    lim_b = stopped ? ps[i] : c;
    lim_s = stopped ? ps[i] + 1 : c;
    nb = 0; n = 0;
    for (int k = 0; k < ns[i]; k++) begin
      t = t0[i] + sof[i][k];
      if (t < lim_b && isb[i][k]) nb++;
      if (t < lim_s) n++;
      if (!stopped && t == c) e.en = 1;
    end
    e.cnt = tri_val(n);
    e.bnc = nb;
    if (stopped) begin e.en = 0; return e; end
    if (nb >= mx[i]) begin e.en = 0; e.done = 1; return e; end
    e.busy = 1;
    return e;
  endfunction

  // ---------------- directed table (instance A: DIV=4, DWELL=2, MAX=3) ----------------
  typedef struct { int c; bit st, sp, rn, en, crn, busy, done; int bnc, cnt; } vec_t;
  vec_t tbl[$];

  function automatic void add(input int c, input bit st, input bit sp, input bit rn,
                              input bit e, input bit r, input bit b, input bit d,
                              input int bc, input int ct);
    vec_t v;
    v = '{c: c, st: st, sp: sp, rn: rn, en: e, crn: r, busy: b, done: d, bnc: bc, cnt: ct};
    tbl.push_back(v);
  endfunction

  initial begin
    int base;
    exp_t e [2];
    bit st, sp, rs;
    int c;

    n_chk = 0; n_fail = 0; cyc = 0;
    rst_n = 0; start = 0; stop = 0;
    build(0, 4, 2, 3);
    build(1, 1, 0, 3);

    //   cyc  st sp rn  en crn bsy dn  bnc cnt
    add(  0, 1, 0, 1,  0, 1, 0, 0,  0,  0);   // reset state, start pulse
    add(  1, 0, 0, 1,  0, 0, 1, 0,  0,  0);   // CLEAR
    add(  2, 0, 0, 1,  0, 1, 1, 0,  0,  0);
    add(  5, 0, 0, 1,  1, 1, 1, 0,  0,  0);   // first strobe
    add(  6, 0, 0, 1,  0, 1, 1, 0,  0,  1);
    add(  9, 0, 0, 1,  1, 1, 1, 0,  0,  1);
    add( 64, 0, 0, 1,  0, 1, 1, 0,  0, 15);   // 15 strobes -> 15
    add( 65, 0, 0, 1,  1, 1, 1, 0,  0, 15);   // bounce strobe
    add( 66, 0, 0, 1,  0, 1, 1, 0,  1, 14);   // dwell
    add( 73, 0, 0, 1,  0, 1, 1, 0,  1, 14);
    add( 77, 0, 0, 1,  1, 1, 1, 0,  1, 14);   // strobes resume
    add(133, 0, 0, 1,  1, 1, 1, 0,  1,  0);   // bounce at down 0
    add(134, 0, 0, 1,  0, 1, 1, 0,  2,  1);
    add(201, 0, 0, 1,  1, 1, 1, 0,  2, 15);
    add(202, 0, 0, 1,  0, 1, 0, 1,  3, 14);   // DONE
    add(210, 1, 1, 1,  0, 1, 0, 1,  3, 14);   // start+stop in DONE
    add(211, 0, 0, 1,  0, 0, 1, 0,  0, 14);   // -> CLEAR
    add(212, 0, 0, 1,  0, 1, 1, 0,  0,  0);
    add(241, 0, 1, 1,  0, 1, 1, 0,  0,  7);   // stop at counter 7
    add(242, 0, 0, 1,  0, 1, 0, 0,  0,  7);
    add(250, 1, 0, 1,  0, 1, 0, 0,  0,  7);
    add(251, 0, 0, 1,  0, 0, 1, 0,  0,  7);
    add(252, 0, 0, 1,  0, 1, 1, 0,  0,  0);
    add(259, 0, 0, 1,  1, 1, 1, 0,  0,  1);
    add(260, 1, 1, 1,  0, 1, 1, 0,  0,  2);   // start+stop in RUN
    add(261, 0, 0, 1,  0, 1, 0, 0,  0,  2);
    add(262, 1, 0, 1,  0, 1, 0, 0,  0,  2);
    add(263, 0, 0, 1,  0, 0, 1, 0,  0,  2);
    add(330, 0, 0, 0,  0, 1, 1, 0,  1, 14);   // reset mid-dwell
    add(331, 0, 0, 1,  0, 1, 0, 0,  0,  0);
    add(332, 0, 0, 1,  0, 1, 0, 0,  0,  0);

    repeat (3) step();
    rst_n = 1;
    base = cyc;

    foreach (tbl[r]) begin
      while (cyc - base < tbl[r].c) begin
        start = 0; stop = 0; rst_n = 1;
        step();
      end
      start = tbl[r].st; stop = tbl[r].sp; rst_n = tbl[r].rn;
      @(negedge clk);
      chk("tbl_cnt_en",    en[0],  tbl[r].en);
      chk("tbl_cnt_rst_n", crn[0], tbl[r].crn);
      chk("tbl_busy",      bsy[0], tbl[r].busy);
      chk("tbl_done",      dn[0],  tbl[r].done);
      chk("tbl_bounces",   bnc[0], tbl[r].bnc);
      chk("tbl_counter",   cnt[0], tbl[r].cnt);
      step();
      start = 0; stop = 0; rst_n = 1;
    end

    // DIV=1, no dwell: strobe every RUN cycle straight through all bounces
    step();
    start = 1;
    step();
    start = 0;
    @(negedge clk);
    chk("b_clear_rst_n", crn[1], 0);
    step();
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      chk("b_cnt_en", en[1], 1);
      chk("b_counter", cnt[1], tri_val(k - 1));
      step();
    end
    @(negedge clk);
    chk("b_done", dn[1], 1);
    chk("b_busy", bsy[1], 0);
    chk("b_bounces", bnc[1], 3);
    chk("b_frozen", cnt[1], 14);
    step();

    // Randomized start/stop/reset against the schedule model
    rst_n = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin t0[i] = -1; ps[i] = -1; held[i] = 0; end

    for (int it = 0; it < 5000; it++) begin
      c = cyc;
      e[0] = model(0, c);
      e[1] = model(1, c);
      st = ($urandom_range(0, 119) == 0);
      sp = ($urandom_range(0, 249) == 0);
      rs = ($urandom_range(0, 1499) == 0);
      if (c == t0[0] || c == t0[1]) st = 0;
      start = st; stop = sp; rst_n = !rs;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("rnd_cnt_en",    en[i],  e[i].en);
        chk("rnd_cnt_rst_n", crn[i], e[i].crn);
        chk("rnd_busy",      bsy[i], e[i].busy);
        chk("rnd_done",      dn[i],  e[i].done);
        chk("rnd_bounces",   bnc[i], e[i].bnc);
        chk("rnd_counter",   cnt[i], e[i].cnt);
      end
      for (int i = 0; i < 2; i++) begin
        if (rs) begin
          t0[i] = -1; ps[i] = -1;
        end else if (sp && e[i].busy) begin
          ps[i] = c;
        end else if (st) begin
          held[i] = model(i, c + 1).cnt;
          t0[i] = c + 1;
          ps[i] = -1;
        end
      end
      step();
    end
    start = 0; stop = 0; rst_n = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
